// File: rtl/frame_rx_2d.sv
// frame_rx_2d: receives a raster-ordered 2D frame of 16-bit elements and
// emits linear-address writes to a frame buffer, one cycle after acceptance.
// Ports: CLK/RST (sync, active-high), VDD/GND ties, row_max/col_max limits
// (latched on sof), in_* element stream with sof/eol/eof markers, in_ready;
// wr_en/wr_addr/wr_data buffer writes, row/col next expected position,
// frame_done pulse with the last write, err sticky framing error.
// Option: define FRAME_RX_2D_MARKER_CHECK_EN to check eol/eof/sof markers
// during a frame and enter an error state on a mismatch.
module frame_rx_2d (
   input  logic        CLK,
   input  logic        RST,
   input  logic        VDD,
   input  logic        GND,
   input  logic [9:0]  row_max,
   input  logic [9:0]  col_max,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   input  logic        in_sof,
   input  logic        in_eol,
   input  logic        in_eof,
   output logic        in_ready,
   output logic        wr_en,
   output logic [19:0] wr_addr,
   output logic [15:0] wr_data,
   output logic [9:0]  row,
   output logic [9:0]  col,
   output logic        frame_done,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t      r_state, w_nstate;
   logic [9:0]  r_row, r_col, w_nrow, w_ncol;
   logic [9:0]  r_rmax, r_cmax, w_nrmax, w_ncmax;
   logic        r_we, w_nwe;
   logic [19:0] r_addr, w_naddr;
   logic [15:0] r_data, w_ndata;
   logic        r_done, w_ndone;
   logic        r_err, w_nerr;
   logic        w_acc, w_last, w_eol, w_bad;
   logic        w_unused;

   // Power ties carry no logic; markers are only read when checking is on.
   assign w_unused = ^{VDD, GND, in_eol, in_eof};

   assign in_ready = !RST && (r_state != DONE);
   assign w_acc    = in_valid && in_ready;
   assign w_eol    = (r_col == r_cmax);
   assign w_last   = w_eol && (r_row == r_rmax);

   always_comb begin
      w_nstate = r_state;
      w_nrow   = r_row;
      w_ncol   = r_col;
      w_nrmax  = r_rmax;
      w_ncmax  = r_cmax;
      w_nwe    = 1'b0;
      w_naddr  = r_addr;
      w_ndata  = r_data;
      w_ndone  = 1'b0;
      w_nerr   = r_err;
      w_bad    = 1'b0;
      unique case (r_state)
         IDLE, ERR: begin
            // Only a start-of-frame element opens a frame; others drop.
            if (w_acc && in_sof) begin
               w_nrmax = row_max;
               w_ncmax = col_max;
               w_nwe   = 1'b1;
               w_naddr = 20'd0;
               w_ndata = in_data;
               w_nerr  = 1'b0;
               if (row_max == 10'd0 && col_max == 10'd0) begin
                  w_nstate = DONE;
                  w_ndone  = 1'b1;
                  w_nrow   = 10'd0;
                  w_ncol   = 10'd0;
               end else if (col_max == 10'd0) begin
                  w_nstate = RECV;
                  w_nrow   = 10'd1;
                  w_ncol   = 10'd0;
               end else begin
                  w_nstate = RECV;
                  w_nrow   = 10'd0;
                  w_ncol   = 10'd1;
               end
            end
         end
         RECV: begin
            if (w_acc) begin
`ifdef FRAME_RX_2D_MARKER_CHECK_EN
               w_bad = in_sof || (in_eol != w_eol) || (in_eof != w_last);
`endif
               if (w_bad) begin
                  w_nstate = ERR;
                  w_nerr   = 1'b1;
                  w_nrow   = 10'd0;
                  w_ncol   = 10'd0;
               end else begin
                  w_nwe   = 1'b1;
                  w_naddr = r_addr + 20'd1;
                  w_ndata = in_data;
                  if (w_last) begin
                     w_nstate = DONE;
                     w_ndone  = 1'b1;
                     w_nrow   = 10'd0;
                     w_ncol   = 10'd0;
                  end else if (w_eol) begin
                     w_nrow = r_row + 10'd1;
                     w_ncol = 10'd0;
                  end else begin
                     w_ncol = r_col + 10'd1;
                  end
               end
            end
         end
         DONE: begin
            w_nstate = IDLE;
            w_nrow   = 10'd0;
            w_ncol   = 10'd0;
         end
         default: w_nstate = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_row   <= 10'd0;
         r_col   <= 10'd0;
         r_rmax  <= 10'd0;
         r_cmax  <= 10'd0;
         r_we    <= 1'b0;
         r_addr  <= 20'd0;
         r_data  <= 16'd0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_row   <= w_nrow;
         r_col   <= w_ncol;
         r_rmax  <= w_nrmax;
         r_cmax  <= w_ncmax;
         r_we    <= w_nwe;
         r_addr  <= w_naddr;
         r_data  <= w_ndata;
         r_done  <= w_ndone;
         r_err   <= w_nerr;
      end
   end

   assign wr_en      = r_we;
   assign wr_addr    = r_addr;
   assign wr_data    = r_data;
   assign row        = r_row;
   assign col        = r_col;
   assign frame_done = r_done;
`ifdef FRAME_RX_2D_MARKER_CHECK_EN
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: doc/frame_rx_2d.md
FRAME_RX_2D -- requirements
Module: frame_rx_2d

Interface
REQ-001 The block SHALL have ports, one per line as name  direction  width  meaning:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- VDD  input  1  power tie; no logic function.
- GND  input  1  ground tie; no logic function.
- row_max  input  10  last row index of the frame, inclusive.
- col_max  input  10  last column index of each row, inclusive.
- in_valid  input  1  an element is offered this cycle.
- in_data  input  16  element payload.
- in_sof  input  1  marker: offered element is (0,0).
- in_eol  input  1  marker: offered element is the last column of its row.
- in_eof  input  1  marker: offered element is the last element of the frame.
- in_ready  output  1  the block can accept an element this cycle.
- wr_en  output  1  write strobe to the frame buffer.
- wr_addr  output  20  linear buffer address.
- wr_data  output  16  data to write.
- row  output  10  row of the next expected element.
- col  output  10  column of the next expected element.
- frame_done  output  1  one-cycle pulse when the last element is written.
- err  output  1  sticky framing-error flag.

Function
REQ-002 An element SHALL be accepted in a cycle where in_valid and in_ready are both 1; no other cycle consumes input.
REQ-003 The FSM SHALL have the states IDLE, RECV, DONE and ERR.
REQ-004 IDLE: in_ready=1. An accepted element with in_sof=1 SHALL latch row_max/col_max and go to RECV. An accepted element with in_sof=0 SHALL be dropped and the FSM SHALL stay in IDLE.
REQ-005 RECV: in_ready=1. Each accepted element SHALL advance (row,col) in raster order: col+1 while col<col_max; at col==col_max, col->0 and row+1.
REQ-006 When (row,col)==(row_max,col_max) is accepted, the FSM SHALL go to DONE.
REQ-007 DONE SHALL last exactly one cycle with in_ready=0, then return to IDLE with row=col=0.
REQ-008 Every accepted element in IDLE (with sof) or RECV SHALL produce wr_en=1 exactly one cycle later.
- wr_data SHALL equal the accepted data.
- wr_addr SHALL equal row*(col_max+1)+col of that element.
- wr_addr SHALL be kept as an incrementing 20-bit register with no multiplier: 0 on sof, +1 per element.
REQ-009 frame_done SHALL pulse in the same cycle as the wr_en of the last element.
REQ-010 Latched limits SHALL stay constant for the whole frame; changes to row_max/col_max mid-frame SHALL have no effect.
REQ-011 row_max=col_max=0 SHALL be a one-element frame: accept with sof -> DONE directly.
REQ-012 ERR: in_ready=1, all input is discarded, wr_en=0, err=1. An accepted element with in_sof=1 SHALL start a new frame exactly as in REQ-004 and clear err.
REQ-013 Outside reset, wr_en SHALL be 0 whenever no element was accepted in the previous cycle.

Reset
REQ-014 While RST=1, at the clock edge the FSM SHALL go to IDLE and set row=0, col=0, wr_addr=0, wr_data=0, wr_en=0, frame_done=0, err=0.
REQ-015 Reset asserted mid-frame SHALL abandon the frame; any write pending for the next cycle SHALL be suppressed.
REQ-016 in_ready SHALL be 0 during any cycle in which RST=1.

Configuration
REQ-017 Macro FRAME_RX_2D_MARKER_CHECK_EN: when defined, marker checking SHALL be active during RECV, and any of the following SHALL go to ERR with no write for that element:
- in_sof=1 on an accepted element.
- in_eol differing from (col==col_max).
- in_eof differing from the element being the last of the frame.
REQ-018 When FRAME_RX_2D_MARKER_CHECK_EN is undefined, in_eol and in_eof SHALL be ignored, a mid-frame in_sof SHALL be treated as data, ERR SHALL be unreachable, and err SHALL be tied to 0.

Verification
REQ-019 The bench SHALL cover these scenarios:
- row_max=1, col_max=2, 6 elements 0x10..0x15 with correct markers -> wr_addr 0..5, data 0x10..0x15, frame_done with the 6th write, in_ready=0 for one cycle.
- row_max=col_max=0, one element with sof+eol+eof -> single write to address 0, frame_done the next cycle.
- Idle gaps (in_valid toggling) inside the frame -> no extra wr_en, addresses stay contiguous.
- With MARKER_CHECK_EN, col_max=3, in_eol asserted at col=1 -> err=1, no write for that element; the next sof restarts at wr_addr=0 and clears err.
- RST asserted after the 3rd accepted element -> no write the following cycle, all outputs per REQ-014; a new sof frame starts at address 0.
- row_max changed mid-frame -> the frame still ends at the originally latched row_max.
